// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide sequencer.
//   - funct codes of the HI/LO instruction group
//   - FSM state encoding
//   - default datapath width and the R-type ALUOp code
package mdu_pkg;

  localparam int         DATA_W_DEF   = 32;
  localparam logic [2:0] RTYPE_OP_DEF = 3'b010;

  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MTHI  = 6'd17;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MTLO  = 6'd19;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

  // True for every funct that touches HI/LO (and therefore must stall while busy).
  function automatic logic is_mdu_fn(input logic [5:0] fn);
    return (fn == FN_MFHI) || (fn == FN_MTHI) || (fn == FN_MFLO) || (fn == FN_MTLO) ||
           (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: iterative datapath for unsigned multiply / divide.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : load operands (hi=0, lo=a_i, b=b_i), clear counter
//   step_i       : perform one iteration
//   div_i        : 1 = restoring divide step, 0 = shift-add multiply step
//   a_i, b_i     : multiplier/dividend (into lo), multiplicand/divisor
//   hi_o, lo_o   : product {hi,lo}, or remainder (hi) / quotient (lo)
//   last_o       : high on the step that completes the last iteration
module mdu_iter_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              div_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              last_o
);

  localparam int CW = $clog2(DATA_W);

  logic [DATA_W-1:0] hi_q, lo_q, b_q;
  logic [CW-1:0]     cnt_q;

  logic [DATA_W:0]   add_sum;  // multiply: partial sum with carry-out
  logic [DATA_W:0]   sh_rem;   // divide: remainder shifted left with next dividend bit
  logic [DATA_W+1:0] diff;     // divide: trial subtraction, MSB is the borrow

  always_comb begin
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    sh_rem  = {hi_q, lo_q[DATA_W-1]};
    diff    = {1'b0, sh_rem} - {2'b00, b_q};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      hi_q  <= '0;
      lo_q  <= a_i;
      b_q   <= b_i;
      cnt_q <= '0;
    end else if (step_i) begin
      cnt_q <= cnt_q + 1'b1;
      if (div_i) begin
        // Remainder always stays below the divisor, so it fits DATA_W bits.
        hi_q <= diff[DATA_W+1] ? sh_rem[DATA_W-1:0] : diff[DATA_W-1:0];
        lo_q <= {lo_q[DATA_W-2:0], ~diff[DATA_W+1]};
      end else begin
        // Multiplier bits are consumed from lo's LSB while product bits enter at its MSB.
        hi_q <= add_sum[DATA_W:1];
        lo_q <= {add_sum[0], lo_q[DATA_W-1:1]};
      end
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign last_o = step_i && (cnt_q == CW'(DATA_W - 1));

endmodule

// File: rtl/mdu_seq_ctrl.sv
// mdu_seq_ctrl: multi-cycle multiply/divide sequencer owning HI/LO.
//   clk_i, rst_i : clock, synchronous active-high reset
//   ALUOp_i      : ALUOp of the EX instruction (R-type marks MDU candidates)
//   funct_i      : funct field of the EX instruction
//   src1_i       : rs (dividend / multiplicand / mthi-mtlo data)
//   src2_i       : rt (divisor / multiplier)
//   stall_o      : freeze IF/ID/EX while an HI/LO instruction waits on a busy unit
//   busy_o       : operation iterating or being sign-corrected
//   done_o       : one-cycle pulse, HI/LO already updated
//   div0_o       : one-cycle pulse alongside done_o for a zero divisor
//   mf_data_o    : HI for mfhi, LO for mflo, else 0
module mdu_seq_ctrl
  import mdu_pkg::*;
#(
  parameter int         DATA_W   = DATA_W_DEF,
  parameter logic [2:0] RTYPE_OP = RTYPE_OP_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        ALUOp_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              div0_o,
  output logic [DATA_W-1:0] mf_data_o
);

  state_e            state_q;
  logic              busy_q, done_q, div0_q;
  logic              sign1_q, sign2_q, isdiv_q, dz_q;
  logic [DATA_W-1:0] hi_q, lo_q;

  logic              is_rt, is_mdu, is_muldiv, is_div, is_sgn;
  logic              s1, s2, accept_md;
  logic [DATA_W-1:0] a_abs, b_abs;
  logic [DATA_W-1:0] core_hi, core_lo;
  logic              core_last, core_step;

  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   q_fix, r_fix, raw_src1;

  // Decode
  assign is_rt     = (ALUOp_i == RTYPE_OP);
  assign is_mdu    = is_rt && is_mdu_fn(funct_i);
  assign is_div    = (funct_i == FN_DIV) || (funct_i == FN_DIVU);
  assign is_sgn    = (funct_i == FN_MULT) || (funct_i == FN_DIV);
  assign is_muldiv = is_rt && (is_div || is_sgn || (funct_i == FN_MULTU));

  // Operand magnitudes; unsigned ops keep the raw value.
  assign s1    = is_sgn && src1_i[DATA_W-1];
  assign s2    = is_sgn && src2_i[DATA_W-1];
  assign a_abs = s1 ? -src1_i : src1_i;
  assign b_abs = s2 ? -src2_i : src2_i;

  // IDLE and DONE are exactly the non-busy states.
  assign accept_md = !busy_q && is_muldiv;
  assign core_step = (state_q == ST_MUL) || (state_q == ST_DIV);

  mdu_iter_core #(.DATA_W(DATA_W)) u_core (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (accept_md),
    .step_i (core_step),
    .div_i  (isdiv_q),
    .a_i    (a_abs),
    .b_i    (b_abs),
    .hi_o   (core_hi),
    .lo_o   (core_lo),
    .last_o (core_last)
  );

  // Sign correction of the unsigned core result.
  assign prod     = {core_hi, core_lo};
  assign prod_fix = (sign1_q ^ sign2_q) ? -prod : prod;
  assign q_fix    = (sign1_q ^ sign2_q) ? -core_lo : core_lo;
  assign r_fix    = sign1_q ? -core_hi : core_hi;
  // On divide-by-zero the core never stepped, so lo still holds |src1|;
  // re-applying the sign recovers the raw dividend (also for -2^31).
  assign raw_src1 = sign1_q ? -core_lo : core_lo;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      isdiv_q <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      div0_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          if (is_rt && funct_i == FN_MTHI) hi_q <= src1_i;
          if (is_rt && funct_i == FN_MTLO) lo_q <= src1_i;
          if (is_muldiv) begin
            sign1_q <= s1;
            sign2_q <= s2;
            isdiv_q <= is_div;
            dz_q    <= is_div && (src2_i == '0);
            busy_q  <= 1'b1;
            if (!is_div)              state_q <= ST_MUL;
            else if (src2_i == '0)    state_q <= ST_FIX;
            else                      state_q <= ST_DIV;
          end
        end
        ST_MUL, ST_DIV: begin
          if (core_last) state_q <= ST_FIX;
        end
        ST_FIX: begin
          if (dz_q) begin
            hi_q <= raw_src1;
            lo_q <= '1;
          end else if (isdiv_q) begin
            hi_q <= r_fix;
            lo_q <= q_fix;
          end else begin
            hi_q <= prod_fix[2*DATA_W-1:DATA_W];
            lo_q <= prod_fix[DATA_W-1:0];
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          div0_q  <= dz_q;
          state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign div0_o    = div0_q;
  assign stall_o   = busy_q && is_mdu;
  assign mf_data_o = (is_rt && funct_i == FN_MFHI) ? hi_q :
                     (is_rt && funct_i == FN_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
module tb_mdu_seq_ctrl;
  import mdu_pkg::*;

  localparam logic [2:0] RT = 3'b010;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [2:0]  ALUOp_i = '0;
  logic [5:0]  funct_i = '0;
  logic [31:0] src1_i = '0, src2_i = '0;
  logic        stall_o, busy_o, done_o, div0_o;
  logic [31:0] mf_data_o;

  mdu_seq_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .ALUOp_i(ALUOp_i), .funct_i(funct_i),
    .src1_i(src1_i), .src2_i(src2_i), .stall_o(stall_o), .busy_o(busy_o),
    .done_o(done_o), .div0_o(div0_o), .mf_data_o(mf_data_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_tot = 0, n_pass = 0;
  logic [31:0] hi_m = '0, lo_m = '0;   // architectural HI/LO of the reference model
  logic [31:0] rd_q[$];                // expected mfhi/mflo results in program order
  int          done_cyc_q[$];          // expected done_o cycle
  bit          done_dz_q[$];           // expected div0_o with that done

  function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endfunction

  // Reference model: ISA-level result of mult/div using 64-bit arithmetic.
  task automatic model(input logic [5:0] fn, input logic [31:0] a, b,
                       output logic [31:0] hi, lo, output bit dz);
    longint      sp, sq, sr;
    logic [63:0] up, uq, ur;
    dz = 0;
    hi = '0; lo = '0;
    case (fn)
      FN_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        up = sp; hi = up[63:32]; lo = up[31:0];
      end
      FN_MULTU: begin
        up = {32'h0, a} * {32'h0, b};
        hi = up[63:32]; lo = up[31:0];
      end
      FN_DIV, FN_DIVU: begin
        if (b == 0) begin
          dz = 1; hi = a; lo = 32'hFFFFFFFF;
        end else if (fn == FN_DIV) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          uq = sq; ur = sr; lo = uq[31:0]; hi = ur[31:0];
        end else begin
          uq = {32'h0, a} / {32'h0, b};
          ur = {32'h0, a} % {32'h0, b};
          lo = uq[31:0]; hi = ur[31:0];
        end
      end
      default: ;
    endcase
  endtask

  task automatic present(input logic [2:0] op, input logic [5:0] fn, input logic [31:0] a, b);
    @(posedge clk_i); #1;
    ALUOp_i = op; funct_i = fn; src1_i = a; src2_i = b;
  endtask

  task automatic read_hilo();
    present(RT, FN_MFHI, 32'h0, 32'h0); rd_q.push_back(hi_m);
    present(RT, FN_MFLO, 32'h0, 32'h0); rd_q.push_back(lo_m);
    present(3'b000, 6'd0, 32'h0, 32'h0);
  endtask

  // Issue one mult/div, optionally k non-MDU R-type cycles, then a dependent
  // HI/LO instruction held until the stall releases, then read HI and LO.
  task automatic run_op(input logic [5:0] fn, input logic [31:0] a, b,
                        input logic [5:0] fu, input int k_in);
    logic [31:0] eh, el, d;
    bit dz;
    int T, stalls, k;
    k = k_in;
    model(fn, a, b, eh, el, dz);
    present(RT, fn, a, b);
    T = cyc;
    done_cyc_q.push_back(T + (dz ? 2 : 34));
    done_dz_q.push_back(dz);
    @(negedge clk_i);
    chk("issue_stall", stall_o, 0);
    hi_m = eh; lo_m = el;
    if (dz) k = 0;
    for (int i = 0; i < k; i++) begin
      present(RT, 6'd32, $urandom, $urandom);
      @(negedge clk_i);
      chk("nonmdu_stall", stall_o, 0);
    end
    d = $urandom;
    present(RT, fu, d, 32'h0);
    if (fu == FN_MFHI) rd_q.push_back(hi_m);
    else if (fu == FN_MFLO) rd_q.push_back(lo_m);
    stalls = 0;
    @(negedge clk_i);
    while (stall_o && stalls <= 60) begin
      stalls++;
      @(negedge clk_i);
    end
    chk("stall_cycles", stalls, dz ? 1 : 33 - k);
    if (fu == FN_MTHI) hi_m = d;
    if (fu == FN_MTLO) lo_m = d;
    read_hilo();
  endtask

  // Reset lands at the end of cycle T+10 of a running divide.
  task automatic abort_div();
    present(RT, FN_DIV, 32'hFFFF1234, 32'h00000013);
    for (int i = 1; i <= 9; i++) present(3'b000, 6'd0, 32'h0, 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("abort_busy_before", busy_o, 1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    ALUOp_i = RT; funct_i = FN_MFLO;
    hi_m = '0; lo_m = '0;
    rd_q.push_back(32'h0);
    @(negedge clk_i);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_stall", stall_o, 0);
    present(RT, FN_MFHI, 32'h0, 32'h0); rd_q.push_back(32'h0);
    // Any late done_o would be flagged by the monitor.
    for (int i = 0; i < 40; i++) present(3'b000, 6'd0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] pick();
    int r;
    r = $urandom_range(0, 4);
    case (r)
      0: return $urandom;
      1: return $urandom_range(0, 20);
      2: return 32'(-int'($urandom_range(1, 20)));
      3: return 32'h80000000;
      default: return 32'hFFFFFFFF;
    endcase
  endfunction

  // Monitor: pops expectations whenever the DUT presents a result.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (ALUOp_i == RT && (funct_i == FN_MFHI || funct_i == FN_MFLO) && !stall_o) begin
        if (rd_q.size() == 0) begin
          n_tot++;
          $display("FAIL unexpected_read: got %0h with no pending read", mf_data_o);
        end else chk("mf_data", mf_data_o, rd_q.pop_front());
      end
      if (done_o) begin
        if (done_cyc_q.size() == 0) begin
          n_tot++;
          $display("FAIL unexpected_done: done_o at cycle %0d with none pending", cyc);
        end else begin
          chk("done_cycle", cyc, done_cyc_q.pop_front());
          chk("div0", div0_o, done_dz_q.pop_front());
        end
      end else if (div0_o) begin
        n_tot++;
        $display("FAIL div0_alone: div0_o=1 without done_o at cycle %0d", cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fn, fu;
    logic [31:0] a, b;
    ALUOp_i = RT; funct_i = FN_MFHI;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_div0", div0_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_mfhi", mf_data_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    ALUOp_i = '0; funct_i = '0;
    read_hilo();

    run_op(FN_MULT,  32'hFFFFFFFD, 32'd7,        FN_MFLO, 0);
    run_op(FN_MULTU, 32'hFFFFFFFF, 32'd2,        FN_MFHI, 0);
    run_op(FN_DIV,   32'hFFFFFFF9, 32'd2,        FN_MFLO, 0);
    run_op(FN_DIVU,  32'd100,      32'd7,        FN_MFHI, 0);
    run_op(FN_DIVU,  32'd5,        32'd0,        FN_MFLO, 0);
    run_op(FN_DIV,   32'h80000000, 32'hFFFFFFFF, FN_MFHI, 0);
    run_op(FN_MULTU, 32'h01234567, 32'h89ABCDEF, FN_MTHI, 3);
    run_op(FN_DIV,   32'hFFFFFFF9, 32'd0,        FN_MTLO, 0);
    abort_div();

    for (int i = 0; i < 40; i++) begin
      fn = FN_MULT + 6'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      if ((fn == FN_DIV || fn == FN_DIVU) && $urandom_range(0, 5) == 0) b = 32'h0;
      fu = FN_MFHI + 6'($urandom_range(0, 3));
      run_op(fn, a, b, fu, $urandom_range(0, 5));
    end

    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    chk("sb_drained", rd_q.size() + done_cyc_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
